// File: rtl/hex_debug_pkg.sv
// hex_debug_pkg: seven-segment code table and nibble decoder shared by the hex debug readout.
// Codes are active-low in {g,f,e,d,c,b,a} order; SEG_BLANK turns every segment off.
package hex_debug_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the glyph for nibble value n (element [0] is the rightmost).
    localparam logic [15:0][6:0] SEG_CODES = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_CODES[nib];
    endfunction

endpackage

// File: rtl/hex_debug_display_key.sv
// key_debounce: synchronises, debounces and edge-detects one active-low pushbutton.
// Ports: clk, rst_n (async active-low), key_n (raw button), press (one-cycle pulse on debounced press).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          hit;

    // hit: this sample is the DEBOUNCE_CYC-th consecutive disagreement
    assign hit = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            level <= hit ? sync[1] : level;
            cnt   <= (sync[1] == level || hit) ? '0 : cnt + 1'b1;
            press <= hit && !sync[1];
        end
    end

endmodule

// File: rtl/hex_debug_display.sv
// hex_debug_display: selects one probe channel and shows it on active-low seven-segment hex digits.
// Ports: clk, rst_n (async active-low), ch_data (NUM_CH packed channels), key_next_n/key_prev_n (raw
// buttons), mode_auto (scan channels), freeze (hold display), sel_idx (current channel), hex_out (digits).
module hex_debug_display
    import hex_debug_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 10,
    parameter int DEBOUNCE_CYC = 4,
    parameter int SCAN_CYC     = 8,
    parameter int BLANK_LZ     = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data,
    input  logic                        key_next_n,
    input  logic                        key_prev_n,
    input  logic                        mode_auto,
    input  logic                        freeze,
    output logic [$clog2(NUM_CH)-1:0]   sel_idx,
    output logic [7*(DATA_W/4)-1:0]     hex_out
);
    localparam int ND = DATA_W / 4;
    localparam int SW = $clog2(NUM_CH);
    localparam int TW = $clog2(SCAN_CYC);

    logic              pn, pp, any, tc, adv, lead;
    logic [TW-1:0]     tmr;
    logic [SW-1:0]     inc, dec;
    logic [DATA_W-1:0] shown_q;
    logic [DATA_W-1:0] ch [NUM_CH];
    logic [3:0]        nib;
    logic [7*ND-1:0]   hex_d;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (.clk(clk), .rst_n(rst_n), .key_n(key_next_n), .press(pn));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prev (.clk(clk), .rst_n(rst_n), .key_n(key_prev_n), .press(pp));

    assign any = pn || pp;
    assign tc  = tmr == TW'(SCAN_CYC - 1);
    // manual presses pre-empt a coincident scan advance
    assign adv = mode_auto && tc && !any;
    assign inc = (sel_idx == SW'(NUM_CH - 1)) ? '0 : sel_idx + 1'b1;
    assign dec = (sel_idx == '0) ? SW'(NUM_CH - 1) : sel_idx - 1'b1;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            ch[c] = ch_data[c*DATA_W +: DATA_W];
    end

    // walk digits from the top; lead stays set while every nibble so far is zero
    always_comb begin
        lead  = 1'b1;
        nib   = '0;
        hex_d = '0;
        for (int d = ND - 1; d >= 0; d--) begin
            nib = shown_q[4*d +: 4];
            lead = lead && (nib == 4'h0);
            hex_d[7*d +: 7] = (BLANK_LZ != 0 && lead && d != 0) ? SEG_BLANK : hex_to_seg(nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr     <= '0;
            sel_idx <= '0;
            shown_q <= '0;
            for (int d = 0; d < ND; d++)
                hex_out[7*d +: 7] <= (BLANK_LZ != 0 && d != 0) ? SEG_BLANK : SEG_CODES[0];
        end else begin
            tmr     <= (!mode_auto || any || tc) ? '0 : tmr + 1'b1;
            sel_idx <= ((pn && !pp) || adv) ? inc : (pp && !pn) ? dec : sel_idx;
            shown_q <= freeze ? shown_q : ch[sel_idx];
            hex_out <= hex_d;
        end
    end

endmodule
